// File: rtl/counter_checker.sv
// counter_checker: locks onto a +1 counter sequence and flags skipped, stalled or corrupted steps
module counter_checker #(
  parameter int W = 8,
  parameter int CW = 16,
  parameter int LOCK_LEN = 4,
  parameter int UNLOCK_LEN = 3
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [W-1:0]  value,
  input  logic          dut_reset,
  output logic          locked,
  output logic          error,
  output logic [CW-1:0] err_count,
  output logic [CW-1:0] wrap_count,
  output logic [W-1:0]  expected
);
  localparam logic HUNT = 1'b0;
  localparam logic LOCKED = 1'b1;
  logic r_state, w_state_nxt;
  logic r_have_prev, r_prev_dr, r_error;
  logic [3:0] r_hunt_cnt, r_miss_cnt;
  logic [CW-1:0] r_err_count, r_wrap_count;
  logic [W-1:0] r_expected;
  logic w_match, w_hunt_done, w_miss_done, w_wrap;
  assign w_match = value == r_expected;
  assign w_hunt_done = r_have_prev && w_match && r_hunt_cnt == 4'(LOCK_LEN - 1);
  assign w_miss_done = !w_match && r_miss_cnt == 4'(UNLOCK_LEN - 1);
  // once locked, a matched 0 can only follow MAX unless the counter itself was reset
  assign w_wrap = w_match && value == '0 && !r_prev_dr;
  always_ff @(posedge clk)
    r_state <= reset ? HUNT : w_state_nxt;
  always_comb
    w_state_nxt = r_state == HUNT ? (w_hunt_done ? LOCKED : HUNT) : (w_miss_done ? HUNT : LOCKED);
  always_ff @(posedge clk) begin
    if (reset) begin
      r_have_prev  <= 1'b0;
      r_prev_dr    <= 1'b0;
      r_error      <= 1'b0;
      r_hunt_cnt   <= '0;
      r_miss_cnt   <= '0;
      r_err_count  <= '0;
      r_wrap_count <= '0;
      r_expected   <= '0;
    end else begin
      r_have_prev <= 1'b1;
      r_prev_dr   <= dut_reset;
      r_expected  <= dut_reset ? '0 : value + 1'b1;
      r_error     <= r_state == LOCKED && !w_match;
      r_hunt_cnt  <= (r_state == HUNT && r_have_prev && w_match) ? r_hunt_cnt + 4'd1 : 4'd0;
      r_miss_cnt  <= (r_state == LOCKED && !w_match) ? r_miss_cnt + 4'd1 : 4'd0;
      if (r_state == LOCKED && !w_match && r_err_count != '1)
        r_err_count <= r_err_count + 1'b1;
      if (r_state == LOCKED && w_wrap && r_wrap_count != '1)
        r_wrap_count <= r_wrap_count + 1'b1;
    end
  end
  always_comb begin
    locked     = r_state == LOCKED;
    error      = r_error;
    err_count  = r_err_count;
    wrap_count = r_wrap_count;
    expected   = r_expected;
  end
endmodule

// File: tb/tb_counter_checker.sv
// tb_counter_checker: directed and randomized checks of counter_checker against a reference model
module tb_counter_checker;
  localparam int W = 8, LL = 4, UL = 3;
  logic clk = 0, reset = 1, dut_reset = 0;
  logic [W-1:0] value = '0, expected, expected_s;
  logic locked, error, locked_s, error_s;
  logic [15:0] err_count, wrap_count;
  logic [1:0] err_s, wrap_s;
  int n_chk = 0, n_err = 0, c = 0, pulses = 0;
  int sat_exp[5] = '{1, 2, 3, 3, 3};
  bit m_lock, m_have, m_error, m_pdr;
  int m_hunt, m_miss, m_err, m_wrap, m_exp, m_prev;

  counter_checker #(.W(W), .CW(16), .LOCK_LEN(LL), .UNLOCK_LEN(UL)) dut (
    .clk(clk), .reset(reset), .value(value), .dut_reset(dut_reset), .locked(locked),
    .error(error), .err_count(err_count), .wrap_count(wrap_count), .expected(expected));
  counter_checker #(.W(W), .CW(2), .LOCK_LEN(LL), .UNLOCK_LEN(UL)) dut_s (
    .clk(clk), .reset(reset), .value(value), .dut_reset(dut_reset), .locked(locked_s),
    .error(error_s), .err_count(err_s), .wrap_count(wrap_s), .expected(expected_s));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int sat(input int n, input int cw);
    return n > (1 << cw) - 1 ? (1 << cw) - 1 : n;
  endfunction

  // behavioural model: hunt for LL good steps, drop lock after UL consecutive misses
  function automatic void model(input bit rs, input int v, input bit dr);
    if (rs) begin
      m_lock = 0; m_have = 0; m_error = 0; m_pdr = 0;
      m_hunt = 0; m_miss = 0; m_err = 0; m_wrap = 0; m_exp = 0; m_prev = -1;
      return;
    end
    m_error = 0;
    if (!m_lock) begin
      if (!m_have) begin m_have = 1; m_hunt = 0; end
      else if (v == m_exp) begin
        m_hunt++;
        if (m_hunt == LL) begin m_lock = 1; m_miss = 0; end
      end else m_hunt = 0;
    end else if (v == m_exp) begin
      m_miss = 0;
      if (v == 0 && m_prev == 255 && !m_pdr) m_wrap++;
    end else begin
      m_error = 1; m_err++; m_miss++;
      if (m_miss == UL) begin m_lock = 0; m_hunt = 0; end
    end
    m_exp = dr ? 0 : (v + 1) % 256;
    m_pdr = dr;
    m_prev = v;
  endfunction

  task automatic step(input int v, input bit dr, input bit rs = 0);
    value = W'(v); dut_reset = dr; reset = rs;
    @(posedge clk);
    model(rs, v & 255, dr);
    #1;
    chk("locked", locked, m_lock);
    chk("error", error, m_error);
    chk("err_count", err_count, sat(m_err, 16));
    chk("wrap_count", wrap_count, sat(m_wrap, 16));
    chk("expected", expected, m_exp);
    chk("err_count_cw2", err_s, sat(m_err, 2));
    chk("wrap_count_cw2", wrap_s, sat(m_wrap, 2));
    if (error_s) pulses++;
  endtask

  task automatic run(input int n);
    repeat (n) begin step(c, 0); c = (c + 1) % 256; end
  endtask

  task automatic go_to(input int t);
    while (c != t) begin step(c, 0); c = (c + 1) % 256; end
  endtask

  initial begin
    step($urandom, 0, 1);
    step($urandom, 0, 1);
    chk("rst_exp", expected, 0);
    chk("rst_lock", locked, 0);
    chk("rst_err", err_count, 0);
    c = 0;
    for (int i = 0; i < 300; i++) begin
      step(c, 0);
      if (i == 3) chk("prelock", locked, 0);
      if (i == 4) chk("lock_at4", locked, 1);
      c = (c + 1) % 256;
    end
    chk("wrap1", wrap_count, 1);
    chk("err0", err_count, 0);
    go_to(10);
    step(10, 0); step(11, 0); step(13, 0);
    chk("skip_pulse", error, 1);
    chk("skip_cnt", err_count, 1);
    step(14, 0);
    chk("skip_lock", locked, 1);
    chk("skip_exp", expected, 15);
    c = 15;
    go_to(20);
    repeat (4) step(20, 0);
    chk("stall_cnt", err_count, 4);
    chk("stall_unlock", locked, 0);
    c = 21;
    for (int i = 0; i < 4; i++) begin
      step(c, 0);
      c++;
      chk("relock", locked, i == 3);
    end
    go_to(42);
    step(42, 1);
    chk("dr_err", error, 0);
    chk("dr_exp", expected, 0);
    step(0, 0);
    chk("dr_exp1", expected, 1);
    step(1, 0); step(2, 0);
    chk("dr_lock", locked, 1);
    chk("dr_errcnt", err_count, 4);
    step(0, 0, 1);
    c = 0;
    run(6);
    pulses = 0;
    for (int i = 0; i < 5; i++) begin
      c = (c + 1) % 256;
      step(c, 0);
      c = (c + 1) % 256;
      chk("sat_cnt", err_s, sat_exp[i]);
      run(3);
    end
    chk("sat_pulses", pulses, 5);
    step(0, 0, 1);
    c = 0;
    for (int i = 0; i < 3000; i++) begin
      int r = $urandom_range(0, 299);
      if (r < 255) run(1);
      else if (r < 270) begin c = (c + $urandom_range(2, 50)) % 256; run(1); end
      else if (r < 282) step((c + 255) % 256, 0);
      else if (r < 290) step($urandom_range(0, 255), 0);
      else if (r < 299) begin step(c, 1); c = 0; end
      else begin step(c, 0, 1); c = 0; end
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
